// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared types, segment codes and BCD helpers for fire_counter_scan
package fire_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;

  // Segment pattern {dp,g,f,e,d,c,b,a}; non-decimal nibbles show nothing
  function automatic logic [7:0] seg_of(input bcd_t bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Binary-to-BCD conversion of an elaboration-time constant, up to 8 digits
  function automatic logic [31:0] to_bcd(input int value);
    int          v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, sample-count debouncer and press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic BTN6,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync_1;
  logic       btn_s;
  logic [7:0] deb_cnt;

  // Bring the raw button into the clk domain
  always_ff @(posedge clk or posedge BTN6) begin
    if (BTN6) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= raw;
      btn_s  <= sync_1;
    end
  end

  // Flip the level after DEB_CYCLES differing samples; pulse press on a 0->1 flip
  always_ff @(posedge clk or posedge BTN6) begin
    if (BTN6) begin
      level   <= 1'b0;
      deb_cnt <= 8'd0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == level) begin
        deb_cnt <= 8'd0;
      end else if (deb_cnt == DEB_LAST) begin
        level   <= btn_s;
        deb_cnt <= 8'd0;
        press   <= btn_s;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fire_counter_scan.sv
// rtl/fire_counter_scan.sv - debounced BCD press counter with scanned 7-segment display (FIRE_LZB_EN: leading-zero blanking)
module fire_counter_scan
  import fire_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int MAX_COUNT  = 9999,
  parameter int DEB_CYCLES = 20,
  parameter int SCAN_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  BTN6,
  input  logic                  BTN1,
  output logic [7:0]            DISP,
  output logic [7:0]            cat,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int              CW        = 4 * DIGITS;
  localparam logic [31:0]     MAX_BCD32 = to_bcd(MAX_COUNT);
  localparam logic [CW-1:0]   MAX_BCD   = MAX_BCD32[CW-1:0];
  localparam logic [2:0]      LAST_IDX  = 3'(DIGITS - 1);
  localparam logic [7:0]      LAST_PRE  = 8'(SCAN_DIV - 1);

  logic              btn_level;
  logic              unused_level;
  logic              press;
  logic              armed;
  logic              carry;
  logic [CW-1:0]     count_inc;
  logic [7:0]        prescale;
  logic [2:0]        scan_idx;
  bcd_t              cur_digit;
  logic              cur_blank;
  logic [DIGITS-1:0] lz_blank;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .BTN6  (BTN6),
    .raw   (BTN1),
    .level (btn_level),
    .press (press)
  );

  // The held level itself is not needed here, only its rising edge
  assign unused_level = btn_level;

  // Ripple the +1 through the BCD digits within a single cycle
  always_comb begin
    carry     = 1'b1;
    count_inc = count_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Count presses, wrapping to zero after MAX_COUNT; armed latches the first press
  always_ff @(posedge clk or posedge BTN6) begin
    if (BTN6) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (press) begin
        armed <= 1'b1;
        if (count_bcd == MAX_BCD) begin
          count_bcd <= '0;
          wrap      <= 1'b1;
        end else begin
          count_bcd <= count_inc;
        end
      end
    end
  end

  // Prescaler sets how long each display position stays lit
  always_ff @(posedge clk or posedge BTN6) begin
    if (BTN6) begin
      prescale <= 8'd0;
      scan_idx <= 3'd0;
    end else if (prescale == LAST_PRE) begin
      prescale <= 8'd0;
      scan_idx <= (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      prescale <= prescale + 8'd1;
    end
  end

`ifdef FIRE_LZB_EN
  logic above_zero;

  // A digit above the units is blank when it and every higher digit are zero
  always_comb begin
    lz_blank   = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      above_zero  = above_zero & (count_bcd[4*i +: 4] == 4'd0);
      lz_blank[i] = above_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Pick the digit and its blanking flag for the position being scanned
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == 3'(i)) begin
        cur_digit = count_bcd[4*i +: 4];
        cur_blank = lz_blank[i];
      end
    end
  end

  // Register cathode select and segments together so they never disagree
  always_ff @(posedge clk or posedge BTN6) begin
    if (BTN6) begin
      DISP <= SEG_BLANK;
      cat  <= 8'hFF;
    end else begin
      cat  <= ~(8'b1 << scan_idx);
      DISP <= (armed && !cur_blank) ? seg_of(cur_digit) : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_fire_counter_scan.sv
// tb/tb_fire_counter_scan.sv - scoreboard bench for fire_counter_scan (DIGITS=4, MAX_COUNT=12, DEB_CYCLES=20, SCAN_DIV=1)
module tb_fire_counter_scan;

  typedef struct packed {
    logic [15:0] cnt;
    logic        wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        BTN6;
  logic        BTN1;
  logic [7:0]  DISP;
  logic [7:0]  cat;
  logic [15:0] count_bcd;
  logic        wrap;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [15:0] prev_cnt;
  logic [7:0]  cat_seq [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

  fire_counter_scan #(
    .DIGITS     (4),
    .MAX_COUNT  (12),
    .DEB_CYCLES (20),
    .SCAN_DIV   (1)
  ) dut (
    .clk       (clk),
    .BTN6      (BTN6),
    .BTN1      (BTN1),
    .DISP      (DISP),
    .cat       (cat),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every change of count_bcd consumes one expected entry
  initial begin : monitor
    exp_t e;
    prev_cnt = 16'h0000;
    forever begin
      @(negedge clk);
      if (count_bcd !== prev_cnt) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_count_change: got %h expected %h", count_bcd, prev_cnt);
        end else begin
          e = sb.pop_front();
          check("count", {16'h0, count_bcd}, {16'h0, e.cnt});
          check("wrap_on_change", {31'h0, wrap}, {31'h0, e.wr});
        end
        prev_cnt = count_bcd;
      end else begin
        check("wrap_idle", {31'h0, wrap}, 32'h0);
      end
    end
  end

  task automatic press_btn(input logic [15:0] exp_cnt, input logic exp_wr);
    sb.push_back('{cnt: exp_cnt, wr: exp_wr});
    BTN1 = 1'b1;
    repeat (30) @(negedge clk);
    BTN1 = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  // exp_disp byte i is the expected DISP while digit i is selected
  task automatic check_scan(input logic [31:0] exp_disp);
    logic [7:0] sel;
    logic [7:0] e;
    logic       found;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        sel = ~(8'b1 << i);
        if (cat === sel) begin
          e = exp_disp[8*i +: 8];
          check($sformatf("disp_digit%0d", i), {24'h0, DISP}, {24'h0, e});
          found = 1'b1;
        end
      end
      if (!found) begin
        tests++;
        fails++;
        $display("FAIL cat_onehot: got %h expected one of FE/FD/FB/F7", cat);
      end
    end
  endtask

  initial begin : stim
    logic [15:0] v;
    BTN6 = 1'b0;
    BTN1 = 1'b0;
    #1 BTN6 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_disp", {24'h0, DISP}, 32'h00);
    check("reset_cat", {24'h0, cat}, 32'hFF);
    check("reset_count", {16'h0, count_bcd}, 32'h0);
    check("reset_wrap", {31'h0, wrap}, 32'h0);
    BTN6 = 1'b0;

    // Idle scan with nothing armed
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("idle_cat", {24'h0, cat}, {24'h0, cat_seq[k % 4]});
      check("idle_disp", {24'h0, DISP}, 32'h00);
      check("idle_count", {16'h0, count_bcd}, 32'h0);
    end

    // 19-sample glitches must never register
    for (int g = 0; g < 5; g++) begin
      BTN1 = 1'b1;
      repeat (19) begin
        @(negedge clk);
        check("glitch_disp", {24'h0, DISP}, 32'h00);
      end
      BTN1 = 1'b0;
      repeat (19) begin
        @(negedge clk);
        check("glitch_disp", {24'h0, DISP}, 32'h00);
      end
    end
    repeat (5) @(negedge clk);
    check("glitch_count", {16'h0, count_bcd}, 32'h0);

    // First press: count changes exactly on edge 23
    sb.push_back('{cnt: 16'h0001, wr: 1'b0});
    BTN1 = 1'b1;
    repeat (22) @(negedge clk);
    check("latency_edge22", {16'h0, count_bcd}, 32'h0);
    @(negedge clk);
    check("latency_edge23", {16'h0, count_bcd}, 32'h0001);
    repeat (7) @(negedge clk);
    BTN1 = 1'b0;
    repeat (30) @(negedge clk);
`ifdef FIRE_LZB_EN
    check_scan(32'h00000006);
`else
    check_scan(32'h3F3F3F06);
`endif

    // Presses up to ten
    for (int n = 2; n <= 9; n++) begin
      v = 16'(n);
      press_btn(v, 1'b0);
    end
    press_btn(16'h0010, 1'b0);
`ifdef FIRE_LZB_EN
    check_scan(32'h0000063F);
`else
    check_scan(32'h3F3F063F);
`endif

    // Wrap after MAX_COUNT=12
    press_btn(16'h0011, 1'b0);
    press_btn(16'h0012, 1'b0);
    press_btn(16'h0000, 1'b1);
`ifdef FIRE_LZB_EN
    check_scan(32'h0000003F);
`else
    check_scan(32'h3F3F3F3F);
`endif

    // Count to 7 then reset mid-count
    for (int n = 1; n <= 7; n++) begin
      v = 16'(n);
      press_btn(v, 1'b0);
    end
    check("pre_reset_count", {16'h0, count_bcd}, 32'h0007);
    sb.push_back('{cnt: 16'h0000, wr: 1'b0});
    #2 BTN6 = 1'b1;
    #1;
    check("midreset_disp", {24'h0, DISP}, 32'h00);
    check("midreset_cat", {24'h0, cat}, 32'hFF);
    check("midreset_count", {16'h0, count_bcd}, 32'h0);
    @(negedge clk);
    #1 BTN6 = 1'b0;
    @(negedge clk);
    check("resume_cat0", {24'h0, cat}, 32'hFE);
    check("resume_disp0", {24'h0, DISP}, 32'h00);
    @(negedge clk);
    check("resume_cat1", {24'h0, cat}, 32'hFD);
    check("resume_disp1", {24'h0, DISP}, 32'h00);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
